// File: rtl/instruction_decode_stage.sv
// Decode stage of the 5-stage MIPS-subset pipeline: IF/ID register, register file,
// early branch/jump resolution, hazard detection and the ID/EX pipeline register.
module instruction_decode_stage #(
    parameter int          NREGS     = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrF,
    input  logic [31:0] pcPlus4F,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic [4:0]  writeRegE,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic [4:0]  writeRegM,
    input  logic [31:0] aluOutM,
    input  logic        regWriteW,
    input  logic [4:0]  writeRegW,
    input  logic [31:0] resultW,
    output logic        hazardDetected,
    output logic        PCSrcD,
    output logic [31:0] PCBranchD,
    output logic        regWriteD2E,
    output logic        memToRegD2E,
    output logic        memWriteD2E,
    output logic        aluSrcD2E,
    output logic        regDstD2E,
    output logic [2:0]  aluCtrlD2E,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [4:0]  rsE,
    output logic [4:0]  rtE,
    output logic [4:0]  rdE,
    output logic [31:0] signImmE
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] instr_d_r;
    logic [31:0] pc_plus4_d_r;
    logic        valid_d_r;
    logic [31:0] regfile_r [NREGS];

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s, rt_s, rd_s;
    logic [31:0] sign_imm_s;
    logic        reg_write_s, mem_to_reg_s, mem_write_s, alu_src_s, reg_dst_s;
    logic [2:0]  alu_ctrl_s;
    logic        is_beq_s, is_bne_s, is_j_s;
    logic [31:0] rd1_s, rd2_s;
    logic [31:0] cmp_a_s, cmp_b_s;
    logic        eq_s;
    logic        lw_stall_s, branch_stall_s;
    logic        unused_shamt_s;

    assign op_s           = instr_d_r[31:26];
    assign funct_s        = instr_d_r[5:0];
    assign rs_s           = instr_d_r[25:21];
    assign rt_s           = instr_d_r[20:16];
    assign rd_s           = instr_d_r[15:11];
    assign sign_imm_s     = {{16{instr_d_r[15]}}, instr_d_r[15:0]};
    assign unused_shamt_s = ^instr_d_r[10:6];

    // Main decoder: unknown opcodes and functs fall through to an all-zero NOP.
    always_comb begin
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        mem_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        reg_dst_s    = 1'b0;
        alu_ctrl_s   = 3'b000;
        is_beq_s     = 1'b0;
        is_bne_s     = 1'b0;
        is_j_s       = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    6'h20:   begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = 3'b010; end
                    6'h22:   begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = 3'b110; end
                    6'h24:   begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = 3'b000; end
                    6'h25:   begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = 3'b001; end
                    6'h2A:   begin reg_write_s = 1'b1; reg_dst_s = 1'b1; alu_ctrl_s = 3'b111; end
                    default: begin reg_write_s = 1'b0; reg_dst_s = 1'b0; alu_ctrl_s = 3'b000; end
                endcase
            end
            OP_LW:   begin reg_write_s = 1'b1; mem_to_reg_s = 1'b1; alu_src_s = 1'b1; alu_ctrl_s = 3'b010; end
            OP_SW:   begin mem_write_s = 1'b1; alu_src_s = 1'b1; alu_ctrl_s = 3'b010; end
            OP_ADDI: begin reg_write_s = 1'b1; alu_src_s = 1'b1; alu_ctrl_s = 3'b010; end
            OP_BEQ:  begin is_beq_s = 1'b1; alu_ctrl_s = 3'b110; end
            OP_BNE:  begin is_bne_s = 1'b1; alu_ctrl_s = 3'b110; end
            OP_J:    begin is_j_s = 1'b1; end
            default: begin reg_write_s = 1'b0; end
        endcase
    end

    // Register-file reads with write-through of the same-cycle writeback.
    always_comb begin
        if (rs_s == 5'd0) begin
            rd1_s = 32'd0;
        end else if (regWriteW && (writeRegW == rs_s)) begin
            rd1_s = resultW;
        end else begin
            rd1_s = regfile_r[rs_s];
        end
        if (rt_s == 5'd0) begin
            rd2_s = 32'd0;
        end else if (regWriteW && (writeRegW == rt_s)) begin
            rd2_s = resultW;
        end else begin
            rd2_s = regfile_r[rt_s];
        end
    end

    // Branch comparator operands, forwarded from MEM when it produces rs/rt.
    always_comb begin
        if (regWriteM && (writeRegM != 5'd0) && (writeRegM == rs_s)) begin
            cmp_a_s = aluOutM;
        end else begin
            cmp_a_s = rd1_s;
        end
        if (regWriteM && (writeRegM != 5'd0) && (writeRegM == rt_s)) begin
            cmp_b_s = aluOutM;
        end else begin
            cmp_b_s = rd2_s;
        end
    end

    assign eq_s = (cmp_a_s == cmp_b_s);

    assign lw_stall_s = memToRegE && (writeRegE != 5'd0) &&
                        ((writeRegE == rs_s) || (writeRegE == rt_s));
    assign branch_stall_s = (is_beq_s || is_bne_s) &&
                            ((regWriteE && (writeRegE != 5'd0) &&
                              ((writeRegE == rs_s) || (writeRegE == rt_s))) ||
                             (memToRegM && (writeRegM != 5'd0) &&
                              ((writeRegM == rs_s) || (writeRegM == rt_s))));

    assign hazardDetected = valid_d_r && (lw_stall_s || branch_stall_s);
    assign PCSrcD = valid_d_r && !hazardDetected &&
                    (is_j_s || (is_beq_s && eq_s) || (is_bne_s && !eq_s));
    assign PCBranchD = is_j_s ? {pc_plus4_d_r[31:28], instr_d_r[25:0], 2'b00}
                              : pc_plus4_d_r + {sign_imm_s[29:0], 2'b00};

    // IF/ID pipeline register: stall holds, redirect flushes to a NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_d_r    <= NOP_INSTR;
            pc_plus4_d_r <= 32'd0;
            valid_d_r    <= 1'b0;
        end else if (hazardDetected) begin
            instr_d_r    <= instr_d_r;
            pc_plus4_d_r <= pc_plus4_d_r;
            valid_d_r    <= valid_d_r;
        end else if (PCSrcD) begin
            instr_d_r    <= NOP_INSTR;
            pc_plus4_d_r <= pcPlus4F;
            valid_d_r    <= 1'b0;
        end else begin
            instr_d_r    <= instrF;
            pc_plus4_d_r <= pcPlus4F;
            valid_d_r    <= 1'b1;
        end
    end

    // Register file; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regfile_r[i] <= 32'd0;
            end
        end else if (regWriteW && (writeRegW != 5'd0)) begin
            regfile_r[writeRegW] <= resultW;
        end
    end

    // ID/EX pipeline register: bubble on stall or an invalid decode slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || hazardDetected || !valid_d_r) begin
            regWriteD2E <= 1'b0;
            memToRegD2E <= 1'b0;
            memWriteD2E <= 1'b0;
            aluSrcD2E   <= 1'b0;
            regDstD2E   <= 1'b0;
            aluCtrlD2E  <= 3'b000;
            rd1E        <= 32'd0;
            rd2E        <= 32'd0;
            rsE         <= 5'd0;
            rtE         <= 5'd0;
            rdE         <= 5'd0;
            signImmE    <= 32'd0;
        end else begin
            regWriteD2E <= reg_write_s;
            memToRegD2E <= mem_to_reg_s;
            memWriteD2E <= mem_write_s;
            aluSrcD2E   <= alu_src_s;
            regDstD2E   <= reg_dst_s;
            aluCtrlD2E  <= alu_ctrl_s;
            rd1E        <= rd1_s;
            rd2E        <= rd2_s;
            rsE         <= rs_s;
            rtE         <= rt_s;
            rdE         <= rd_s;
            signImmE    <= sign_imm_s;
        end
    end

endmodule
